// File: rtl/iterative_divider_if.sv
// Handshake and data bundle for iterative_divider.
// signed_mode/overflow exist only when SIGNED_DIV_EN is defined.
interface iterative_divider_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] dividend;
  logic [DATA_WIDTH-1:0] divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] quotient;
  logic [DATA_WIDTH-1:0] remainder;
  logic                  div_by_zero;
`ifdef SIGNED_DIV_EN
  logic                  signed_mode;
  logic                  overflow;
`endif

  modport master (
    output in_valid,
    output dividend,
    output divisor,
    output out_ready,
`ifdef SIGNED_DIV_EN
    output signed_mode,
    input  overflow,
`endif
    input  in_ready,
    input  out_valid,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  in_valid,
    input  dividend,
    input  divisor,
    input  out_ready,
`ifdef SIGNED_DIV_EN
    input  signed_mode,
    output overflow,
`endif
    output in_ready,
    output out_valid,
    output quotient,
    output remainder,
    output div_by_zero
  );
endinterface

// File: rtl/iterative_divider.sv
// Restoring divider producing one quotient bit per cycle, MSB first.
// Define SIGNED_DIV_EN to add two's-complement division (signed_mode/overflow).
module iterative_divider #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input logic                clk,
  input logic                rst,
  iterative_divider_if.slave bus
);
  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned CntW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;
  state_e state_q, state_d;

  // dvd_q shifts dividend bits out at the top and quotient bits in at the bottom
  logic [W-1:0]    dvd_q, dvd_d;
  logic [W-1:0]    dsr_q, dsr_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            quo_neg_q, quo_neg_d;
  logic            rem_neg_q, rem_neg_d;
  logic [W-1:0]    quo_res_q, quo_res_d;
  logic [W-1:0]    rem_res_q, rem_res_d;
  logic            dbz_q, dbz_d;
`ifdef SIGNED_DIV_EN
  localparam logic [W-1:0] MinNeg = {1'b1, {(W-1){1'b0}}};
  logic            ovf_pend_q, ovf_pend_d;
  logic            ovf_q, ovf_d;
  logic            ovf_case;
`endif

  logic         signed_en;
  logic         a_neg, b_neg;
  logic [W-1:0] mag_a, mag_b;
  logic [W:0]   shifted, sub;
  logic         ge;
  logic [W-1:0] step_rem, step_quo;

`ifdef SIGNED_DIV_EN
  assign signed_en = bus.signed_mode;
  assign ovf_case  = signed_en && (bus.dividend == MinNeg) && (bus.divisor == '1);
`else
  assign signed_en = 1'b0;
`endif

  assign a_neg = signed_en & bus.dividend[W-1];
  assign b_neg = signed_en & bus.divisor[W-1];
  assign mag_a = a_neg ? -bus.dividend : bus.dividend;
  assign mag_b = b_neg ? -bus.divisor : bus.divisor;

  // Partial remainder stays below the divisor, so W bits suffice between steps.
  assign shifted  = {rem_q, dvd_q[W-1]};
  assign sub      = shifted - {1'b0, dsr_q};
  assign ge       = (shifted >= {1'b0, dsr_q});
  assign step_rem = ge ? W'(sub) : W'(shifted);
  assign step_quo = {dvd_q[W-2:0], ge};

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    quo_res_d = quo_res_q;
    rem_res_d = rem_res_q;
    dbz_d     = dbz_q;
`ifdef SIGNED_DIV_EN
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          if (bus.divisor == '0) begin
            state_d   = StDone;
            quo_res_d = '1;
            rem_res_d = bus.dividend;
            dbz_d     = 1'b1;
`ifdef SIGNED_DIV_EN
            ovf_d     = 1'b0;
`endif
          end else begin
            state_d   = StCalc;
            dvd_d     = mag_a;
            dsr_d     = mag_b;
            rem_d     = '0;
            cnt_d     = CntW'(W - 1);
            quo_neg_d = a_neg ^ b_neg;
            rem_neg_d = a_neg;
`ifdef SIGNED_DIV_EN
            ovf_pend_d = ovf_case;
`endif
          end
        end
      end
      StCalc: begin
        rem_d = step_rem;
        dvd_d = step_quo;
        if (cnt_q == '0) begin
          state_d   = StDone;
          quo_res_d = quo_neg_q ? -step_quo : step_quo;
          rem_res_d = rem_neg_q ? -step_rem : step_rem;
          dbz_d     = 1'b0;
`ifdef SIGNED_DIV_EN
          ovf_d     = ovf_pend_q;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      quo_res_q <= '0;
      rem_res_q <= '0;
      dbz_q     <= 1'b0;
`ifdef SIGNED_DIV_EN
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      quo_res_q <= quo_res_d;
      rem_res_q <= rem_res_d;
      dbz_q     <= dbz_d;
`ifdef SIGNED_DIV_EN
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign bus.in_ready    = (state_q == StIdle);
  assign bus.out_valid   = (state_q == StDone);
  assign bus.quotient    = quo_res_q;
  assign bus.remainder   = rem_res_q;
  assign bus.div_by_zero = dbz_q;
`ifdef SIGNED_DIV_EN
  assign bus.overflow    = ovf_q;
`endif
endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: directed cases plus randomized
// operands against a plain-arithmetic reference model.
module tb_iterative_divider;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst;

  iterative_divider_if #(.DATA_WIDTH(W)) dif ();

  iterative_divider #(.DATA_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] got_q, got_r;
  logic         got_dbz;
  int           got_lat;
`ifdef SIGNED_DIV_EN
  logic         tb_signed = 1'b0;
  logic         got_ovf;
`endif

  // Present one operation from IDLE, wait for its result; leaves time #1 after
  // the edge on which out_valid rose. got_lat counts edges from accept to first
  // edge that sees out_valid; -1 on timeout.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    @(negedge clk);
    dif.in_valid = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
`ifdef SIGNED_DIV_EN
    dif.signed_mode = tb_signed;
`endif
    n = 0;
    while (!dif.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
    dif.dividend = W'($urandom);
    dif.divisor  = W'($urandom);
`ifdef SIGNED_DIV_EN
    dif.signed_mode = ~tb_signed;
`endif
    n = 0;
    while (!dif.out_valid && n < 4 * W) begin
      @(posedge clk);
      #1;
      n++;
    end
    got_lat = dif.out_valid ? n + 1 : -1;
    got_q   = dif.quotient;
    got_r   = dif.remainder;
    got_dbz = dif.div_by_zero;
`ifdef SIGNED_DIV_EN
    got_ovf = dif.overflow;
`endif
  endtask

  task automatic finish_op();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dif.in_valid  = 1'b1;
    dif.dividend  = 16'h00AA;
    dif.divisor   = 16'h0000;
    dif.out_ready = 1'b1;
`ifdef SIGNED_DIV_EN
    dif.signed_mode = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (dif.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", dif.in_ready);
    end
    n_tests++;
    if (dif.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", dif.out_valid);
    end
    n_tests++;
    if (dif.quotient !== '0) begin
      n_fail++; $display("FAIL reset_quotient: got %h want 0", dif.quotient);
    end
    n_tests++;
    if (dif.remainder !== '0) begin
      n_fail++; $display("FAIL reset_remainder: got %h want 0", dif.remainder);
    end
    n_tests++;
    if (dif.div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL reset_dbz: got %b want 0", dif.div_by_zero);
    end
`ifdef SIGNED_DIV_EN
    n_tests++;
    if (dif.overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_overflow: got %b want 0", dif.overflow);
    end
`endif
    @(negedge clk);
    dif.in_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_op(16'd100, 16'd7);
    n_tests++;
    if (got_lat !== W + 1) begin
      n_fail++; $display("FAIL basic_latency: got %0d want %0d", got_lat, W + 1);
    end
    n_tests++;
    if (got_q !== 16'd14) begin
      n_fail++; $display("FAIL basic_quotient: got %0d want 14", got_q);
    end
    n_tests++;
    if (got_r !== 16'd2) begin
      n_fail++; $display("FAIL basic_remainder: got %0d want 2", got_r);
    end
    n_tests++;
    if (got_dbz !== 1'b0) begin
      n_fail++; $display("FAIL basic_dbz: got %b want 0", got_dbz);
    end
    finish_op();
  endtask

  task automatic test_div_zero();
    run_op(16'h1234, 16'h0000);
    n_tests++;
    if (got_lat !== 1) begin
      n_fail++; $display("FAIL dz_latency: got %0d want 1", got_lat);
    end
    n_tests++;
    if (got_q !== 16'hFFFF) begin
      n_fail++; $display("FAIL dz_quotient: got %h want ffff", got_q);
    end
    n_tests++;
    if (got_r !== 16'h1234) begin
      n_fail++; $display("FAIL dz_remainder: got %h want 1234", got_r);
    end
    n_tests++;
    if (got_dbz !== 1'b1) begin
      n_fail++; $display("FAIL dz_flag: got %b want 1", got_dbz);
    end
    finish_op();
  endtask

  task automatic test_hold();
    dif.out_ready = 1'b0;
    run_op(16'hFFFF, 16'h0001);
    n_tests++;
    if (got_lat !== W + 1) begin
      n_fail++; $display("FAIL hold_latency: got %0d want %0d", got_lat, W + 1);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (dif.out_valid !== 1'b1 || dif.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_handshake[%0d]: got valid=%b ready=%b want valid=1 ready=0",
                 i, dif.out_valid, dif.in_ready);
      end
      n_tests++;
      if (dif.quotient !== 16'hFFFF || dif.remainder !== 16'h0000) begin
        n_fail++;
        $display("FAIL hold_data[%0d]: got q=%h r=%h want q=ffff r=0000",
                 i, dif.quotient, dif.remainder);
      end
    end
    dif.out_ready = 1'b1;
    finish_op();
    n_tests++;
    if (dif.out_valid !== 1'b0 || dif.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_consume: got valid=%b ready=%b want valid=0 ready=1",
               dif.out_valid, dif.in_ready);
    end
    n_tests++;
    if (dif.quotient !== 16'hFFFF) begin
      n_fail++; $display("FAIL hold_retain: got %h want ffff", dif.quotient);
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    @(negedge clk);
    dif.in_valid = 1'b1;
    dif.dividend = 16'd500;
    dif.divisor  = 16'd3;
    @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_tests++;
    if (dif.in_ready !== 1'b1 || dif.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: got ready=%b valid=%b want ready=1 valid=0",
               dif.in_ready, dif.out_valid);
    end
    n_tests++;
    if (dif.quotient !== '0 || dif.remainder !== '0) begin
      n_fail++;
      $display("FAIL abort_result: got q=%h r=%h want 0 0", dif.quotient, dif.remainder);
    end
    seen = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(posedge clk);
      #1;
      if (dif.out_valid) seen++;
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL abort_no_result: got %0d valid cycles want 0", seen);
    end
    run_op(16'd9, 16'd4);
    n_tests++;
    if (got_q !== 16'd2 || got_r !== 16'd1) begin
      n_fail++; $display("FAIL abort_next_op: got q=%0d r=%0d want q=2 r=1", got_q, got_r);
    end
    finish_op();
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, exp_q, exp_r;
    logic         exp_dbz;
    int           exp_lat, stall;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      if (i % 8 == 0)      b = '0;
      else if (i % 3 == 0) b = W'($urandom_range(1, 15));
      else                 b = W'($urandom);
      if (b == '0) begin
        exp_q = '1; exp_r = a; exp_dbz = 1'b1; exp_lat = 1;
      end else begin
        exp_q = a / b; exp_r = a % b; exp_dbz = 1'b0; exp_lat = W + 1;
      end
      stall = $urandom_range(0, 3);
      dif.out_ready = (stall == 0);
      run_op(a, b);
      n_tests++;
      if (got_q !== exp_q || got_r !== exp_r || got_dbz !== exp_dbz) begin
        n_fail++;
        $display("FAIL rand_result %h/%h: got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                 a, b, got_q, got_r, got_dbz, exp_q, exp_r, exp_dbz);
      end
      n_tests++;
      if (got_lat !== exp_lat) begin
        n_fail++; $display("FAIL rand_latency %h/%h: got %0d want %0d", a, b, got_lat, exp_lat);
      end
      if (stall != 0) begin
        repeat (stall) @(posedge clk);
        #1;
        n_tests++;
        if (dif.out_valid !== 1'b1 || dif.quotient !== exp_q || dif.remainder !== exp_r) begin
          n_fail++;
          $display("FAIL rand_stall: got valid=%b q=%h r=%h want valid=1 q=%h r=%h",
                   dif.out_valid, dif.quotient, dif.remainder, exp_q, exp_r);
        end
        dif.out_ready = 1'b1;
      end
      finish_op();
    end
  endtask

`ifdef SIGNED_DIV_EN
  task automatic test_signed();
    logic [W-1:0] a, b, exp_q, exp_r;
    logic signed [W-1:0] sa, sb;
    logic exp_ovf;
    tb_signed = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i == 0)      begin a = 16'hFFF9; b = 16'h0002; end
      else if (i == 1) begin a = 16'h8000; b = 16'hFFFF; end
      else if (i == 2) begin a = 16'h8123; b = 16'h0000; end
      else begin a = W'($urandom); b = W'($urandom_range(1, 40)); b = (i % 2) ? -b : b; end
      sa = a;
      sb = b;
      exp_ovf = 1'b0;
      if (b == '0) begin
        exp_q = '1; exp_r = a;
      end else if (a == 16'h8000 && b == 16'hFFFF) begin
        exp_q = 16'h8000; exp_r = '0; exp_ovf = 1'b1;
      end else begin
        exp_q = sa / sb; exp_r = sa % sb;
      end
      run_op(a, b);
      n_tests++;
      if (got_q !== exp_q || got_r !== exp_r || got_ovf !== exp_ovf) begin
        n_fail++;
        $display("FAIL signed %h/%h: got q=%h r=%h ovf=%b want q=%h r=%h ovf=%b",
                 a, b, got_q, got_r, got_ovf, exp_q, exp_r, exp_ovf);
      end
      n_tests++;
      if (got_lat !== ((b == '0) ? 1 : W + 1) || got_dbz !== (b == '0)) begin
        n_fail++;
        $display("FAIL signed_timing %h/%h: got lat=%0d dbz=%b", a, b, got_lat, got_dbz);
      end
      finish_op();
    end
    tb_signed = 1'b0;
  endtask
`endif

  initial begin
    dif.in_valid  = 1'b0;
    dif.dividend  = '0;
    dif.divisor   = '0;
    dif.out_ready = 1'b1;
`ifdef SIGNED_DIV_EN
    dif.signed_mode = 1'b0;
`endif
    rst = 1'b1;
    test_reset();
    test_basic();
    test_div_zero();
    test_hold();
    test_reset_abort();
    test_random();
`ifdef SIGNED_DIV_EN
    test_signed();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/iterative_divider.md
ITERATIVE_DIVIDER -- requirements
Module: iterative_divider

Interface
REQ-001 Parameter DATA_WIDTH, default 16: operand and result width in bits, minimum 2.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  dividend/divisor valid.
REQ-005 in_ready  output  1  block can accept an operation.
REQ-006 dividend  input  DATA_WIDTH  numerator.
REQ-007 divisor  input  DATA_WIDTH  denominator.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 quotient  output  DATA_WIDTH  result quotient.
REQ-011 remainder  output  DATA_WIDTH  result remainder.
REQ-012 div_by_zero  output  1  divisor was zero for the presented result.
REQ-013 signed_mode  input  1  operands are two's complement (present only with SIGNED_DIV_EN).
REQ-014 overflow  output  1  signed result unrepresentable (present only with SIGNED_DIV_EN).

Function
REQ-015 States SHALL be IDLE, CALC, DONE; in_ready SHALL equal (state == IDLE), registered-state decode only.
REQ-016 Acceptance SHALL occur on an edge with in_valid && in_ready; operands latched internally, later input changes ignored.
REQ-017 Accept with divisor != 0: IDLE -> CALC; CALC SHALL run exactly DATA_WIDTH cycles, one quotient bit per cycle, MSB first.
REQ-018 Each CALC cycle: partial remainder (DATA_WIDTH+1 bits) shifted left with next dividend bit; trial subtract of zero-extended divisor; no borrow -> keep difference, quotient bit 1; borrow -> restore, quotient bit 0.
REQ-019 After the last CALC cycle: -> DONE, out_valid=1; out_valid first high DATA_WIDTH+1 cycles after the acceptance edge.
REQ-020 Accept with divisor == 0: IDLE -> DONE directly; quotient all ones, remainder = dividend, div_by_zero=1; out_valid high 1 cycle after acceptance edge.
REQ-021 DONE: quotient, remainder, div_by_zero, overflow SHALL hold stable while out_valid && !out_ready.
REQ-022 out_valid && out_ready on an edge: DONE -> IDLE, out_valid=0; result outputs retain last values until next result.
REQ-023 No overlap: a new operation SHALL NOT be accepted in the same cycle a result is consumed (in_ready low throughout DONE).
REQ-024 Unsigned results SHALL satisfy dividend == quotient*divisor + remainder, remainder < divisor.

Reset
REQ-025 rst high at an edge SHALL force IDLE from any state, aborting any CALC in progress with no result produced.
REQ-026 Reset values: in_ready=1 (after reset edge), out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0.
REQ-027 rst SHALL take priority over in_valid and out_ready in the same cycle.

Configuration
REQ-028 Macro SIGNED_DIV_EN: defined -> signed_mode and overflow ports exist; undefined -> ports absent, all division unsigned.
REQ-029 With SIGNED_DIV_EN and signed_mode=1 latched at acceptance: operands converted to magnitude, unsigned core used, quotient negated if operand signs differ, remainder takes dividend sign (truncation toward zero); latency unchanged.
REQ-030 Signed most-negative / -1: quotient = most-negative value, remainder 0, overflow=1.
REQ-031 Signed divide-by-zero: quotient all ones, remainder = dividend, div_by_zero=1, overflow=0.

Verification
REQ-032 DATA_WIDTH=16, 100/7, out_ready=1 -> out_valid 17 cycles after accept, quotient 14, remainder 2, div_by_zero 0.
REQ-033 0x1234/0 -> out_valid 1 cycle after accept, quotient 0xFFFF, remainder 0x1234, div_by_zero 1.
REQ-034 0xFFFF/1 with out_ready low 5 cycles after out_valid -> quotient 0xFFFF, remainder 0 held stable all 5 cycles; in_ready low until consume edge.
REQ-035 Accept 500/3, assert rst at CALC cycle 8 -> next cycle IDLE, in_ready 1, out_valid 0, no result; following 9/4 -> quotient 2, remainder 1.
REQ-036 SIGNED_DIV_EN, signed_mode=1: -7/2 -> quotient 0xFFFD, remainder 0xFFFF; 0x8000/0xFFFF -> quotient 0x8000, remainder 0, overflow 1.
